// File: rtl/mac16_pkg.sv
// mac16_pkg: shared types and default widths for the 16x16 multiply-accumulate
// controller slice.
//   state_e     : controller FSM state encoding
//   DEF_*_W     : default operand / accumulator / count widths
//   PROD_W      : product width returned by the array multiplier
package mac16_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_CNT_W  = 8;
    localparam int PROD_W     = 2 * DEF_DATA_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MULT = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mac16_acc_add.sv
// mac16_acc_add: combinational accumulator adder.
// Adds the zero-extended product to the running sum and returns the next
// accumulator value.
// Build option: MAC_SATURATE_EN
//   defined   - a carry out of ACC_W bits clamps the result to all ones
//   undefined - the sum wraps modulo 2^ACC_W
// Ports:
//   acc_i  in  ACC_W  current accumulator
//   prod_i in  PRD_W  registered product
//   acc_o  out ACC_W  next accumulator value
module mac16_acc_add
    import mac16_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int PRD_W = PROD_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [PRD_W-1:0] prod_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] prod_ext;

    assign prod_ext = ACC_W'(prod_i);

`ifdef MAC_SATURATE_EN
    logic [ACC_W:0] sum_full;

    assign sum_full = {1'b0, acc_i} + {1'b0, prod_ext};
    // Once clamped, any further non-zero product carries again, so the sum
    // stays pinned at all ones for the rest of the burst.
    assign acc_o = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_o = acc_i + prod_ext;
`endif

endmodule

// File: rtl/mac16_accum_ctrl.sv
// mac16_accum_ctrl: sequencing and accumulate stage around a combinational
// 16x16 unsigned multiplier. Accepts operand pairs over valid/ready,
// registers them onto the multiplier, registers the product, accumulates
// len products and presents the sum over valid/ready.
// Build option: MAC_SATURATE_EN (saturating accumulate, see mac16_acc_add).
// Ports:
//   clk, reset (async, active-high)
//   start, len             : begin a sum of len products (sampled in IDLE)
//   in_valid/in_ready      : operand handshake, in_a / in_b operands
//   mult_a/mult_b          : registered operands to the multiplier
//   mult_result            : product from the multiplier
//   out_valid/out_ready    : result handshake, out_acc sum
//   busy                   : high outside IDLE
//
// state | meaning
// IDLE  | waiting for start; len latched, acc cleared on start
// LOAD  | in_ready high, waiting for an operand pair
// MULT  | multiplier settles on registered operands; product captured
// ACC   | product added into acc, count decremented
// DONE  | out_valid high with final sum until out_ready
module mac16_accum_ctrl
    import mac16_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic [DATA_W-1:0]   mult_a,
    output logic [DATA_W-1:0]   mult_b,
    input  logic [2*DATA_W-1:0] mult_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_acc,
    output logic                busy
);

    localparam int MR_W = 2 * DATA_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [MR_W-1:0]    prod_q, prod_d;
    logic [DATA_W-1:0]  mult_a_q, mult_a_d;
    logic [DATA_W-1:0]  mult_b_q, mult_b_d;
    logic [ACC_W-1:0]   acc_sum;

    mac16_acc_add #(
        .ACC_W (ACC_W),
        .PRD_W (MR_W)
    ) u_acc_add (
        .acc_i  (acc_q),
        .prod_i (prod_q),
        .acc_o  (acc_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = '0;
                    state_d = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mult_a_d = in_a;
                    mult_b_d = in_b;
                    state_d  = MULT;
                end
            end
            MULT: begin
                prod_d  = mult_result;
                state_d = ACC;
            end
            ACC: begin
                acc_d   = acc_sum;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : LOAD;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;

endmodule
